// File: rtl/code_stepper_if.sv
// Button/switch inputs and code outputs of the code stepper, grouped as one port.
// master drives the raw controls and observes the code; slave is the stepper itself.
interface code_stepper_if;
    logic       btnUp;
    logic       btnDown;
    logic       autoRun;
    logic [2:0] codeOut;
    logic       stepPulse;

    modport master (
        output btnUp,
        output btnDown,
        output autoRun,
        input  codeOut,
        input  stepPulse
    );

    modport slave (
        input  btnUp,
        input  btnDown,
        input  autoRun,
        output codeOut,
        output stepPulse
    );
endinterface

// File: rtl/code_stepper.sv
// 3-bit LED code stepped by debounced up/down buttons or a periodic auto-run tick.
// Press to new code: DEBOUNCE_CYCLES+3 edges; no backpressure, every event is applied at once.
module code_stepper #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int STEP_DIV        = 25000000
) (
    input logic           clk,
    input logic           rst,
    code_stepper_if.slave bus
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(STEP_DIV - 1);

    typedef enum logic {IDLE, RUN} run_state_t;

    // bit 0 = up, bit 1 = down, bit 2 = autoRun
    logic [2:0]    sync1, sync2;
    logic [1:0]    stable;
    logic [1:0]    press;
    logic [CW-1:0] dcnt [2];

    run_state_t    state, state_nxt;
    logic [PW-1:0] pre, pre_nxt;
    logic [2:0]    code, code_nxt;
    logic          pulse;
    logic          run_sync;
    logic          manual;
    logic          auto_step;

    assign run_sync = sync2[2];
    assign manual   = press[0] | press[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {bus.autoRun, bus.btnDown, bus.btnUp};
            sync2 <= sync1;
        end
    end

    // press is registered so the code moves one edge after the level is accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            stable <= '0;
            press  <= '0;
            dcnt[0] <= '0;
            dcnt[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                press[i] <= 1'b0;
                if (sync2[i] == stable[i]) begin
                    dcnt[i] <= '0;
                end else if (dcnt[i] == DB_LAST) begin
                    stable[i] <= sync2[i];
                    dcnt[i]   <= '0;
                    press[i]  <= sync2[i];
                end else begin
                    dcnt[i] <= dcnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pre   <= '0;
            code  <= '0;
            pulse <= 1'b0;
        end else begin
            state <= state_nxt;
            pre   <= pre_nxt;
            code  <= code_nxt;
            pulse <= (code_nxt != code);
        end
    end

    always_comb begin
        state_nxt = state;
        pre_nxt   = pre;
        auto_step = 1'b0;
        code_nxt  = code;

        case (state)
            IDLE: begin
                pre_nxt = '0;
                if (run_sync) state_nxt = RUN;
            end
            RUN: begin
                if (manual) begin
                    pre_nxt = '0;
                end else if (pre == PRE_LAST) begin
                    pre_nxt   = '0;
                    auto_step = 1'b1;
                end else begin
                    pre_nxt = pre + 1'b1;
                end
                // leaving RUN drops any partial interval so IDLE sits at zero
                if (!run_sync) begin
                    state_nxt = IDLE;
                    pre_nxt   = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                pre_nxt   = '0;
            end
        endcase

        case (press)
            2'b01:   code_nxt = code + 3'd1;
            2'b10:   code_nxt = code - 3'd1;
            2'b11:   code_nxt = code;
            default: if (auto_step) code_nxt = code + 3'd1;
        endcase
    end

    assign bus.codeOut   = code;
    assign bus.stepPulse = pulse;
endmodule

// File: tb/tb_code_stepper.sv
// Directed plus random stimulus for code_stepper, checked every cycle against a
// cycle-level reference model of the debounce/auto-step rules.
module tb_code_stepper;
    localparam int D = 4;
    localparam int S = 8;

    logic clk;
    logic rst;
    code_stepper_if bus();

    code_stepper #(.DEBOUNCE_CYCLES(D), .STEP_DIV(S)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    // reference model state: raw inputs seen through a two-sample delay line,
    // per-button disagreement age, pending press, interval position
    int m_d1 [3];
    int m_d2 [3];
    int m_level [2];
    int m_age [2];
    int m_evt [2];
    int m_run;
    int m_since;
    int m_code;
    int m_pulse;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int raw [3];
        int up, dn, auto_hit, nc;
        raw[0] = int'(bus.btnUp);
        raw[1] = int'(bus.btnDown);
        raw[2] = int'(bus.autoRun);
        if (rst) begin
            for (int i = 0; i < 3; i++) begin m_d1[i] = 0; m_d2[i] = 0; end
            for (int i = 0; i < 2; i++) begin m_level[i] = 0; m_age[i] = 0; m_evt[i] = 0; end
            m_run = 0; m_since = 0; m_code = 0; m_pulse = 0;
            return;
        end
        up = m_evt[0];
        dn = m_evt[1];
        auto_hit = 0;
        if (m_run != 0) begin
            if (up != 0 || dn != 0) m_since = 0;
            else begin
                m_since++;
                if (m_since == S) begin auto_hit = 1; m_since = 0; end
            end
        end else begin
            m_since = 0;
        end
        if (up != 0 && dn == 0)      nc = (m_code + 1) % 8;
        else if (dn != 0 && up == 0) nc = (m_code + 7) % 8;
        else if (up != 0 && dn != 0) nc = m_code;
        else if (auto_hit != 0)      nc = (m_code + 1) % 8;
        else                         nc = m_code;
        m_pulse = (nc != m_code) ? 1 : 0;
        m_code = nc;
        // a level is accepted once it has disagreed for D consecutive cycles
        for (int i = 0; i < 2; i++) begin
            m_evt[i] = 0;
            if (m_d2[i] == m_level[i]) m_age[i] = 0;
            else begin
                m_age[i]++;
                if (m_age[i] == D) begin
                    m_level[i] = m_d2[i];
                    m_age[i] = 0;
                    m_evt[i] = m_level[i];
                end
            end
        end
        m_run = m_d2[2];
        for (int i = 0; i < 3; i++) begin
            m_d2[i] = m_d1[i];
            m_d1[i] = raw[i];
        end
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            model_edge();
            #1;
            chk("code_vs_model", {29'd0, bus.codeOut}, m_code);
            chk("pulse_vs_model", {31'd0, bus.stepPulse}, m_pulse);
        end
    endtask

    task automatic press_up();
        bus.btnUp = 1'b1; step(8);
        bus.btnUp = 1'b0; step(8);
    endtask

    initial begin
        int lim;
        rst = 1'b1;
        bus.btnUp = 1'b0;
        bus.btnDown = 1'b0;
        bus.autoRun = 1'b0;
        step(3);
        chk("reset_code", {29'd0, bus.codeOut}, 0);
        chk("reset_pulse", {31'd0, bus.stepPulse}, 0);

        // single press: new code exactly D+3 edges after the rise
        rst = 1'b0;
        step(2);
        bus.btnUp = 1'b1;
        step(6);
        chk("up_before_latency", {29'd0, bus.codeOut}, 0);
        step(1);
        chk("up_at_latency", {29'd0, bus.codeOut}, 1);
        chk("up_pulse_on", {31'd0, bus.stepPulse}, 1);
        step(1);
        chk("up_pulse_off", {31'd0, bus.stepPulse}, 0);
        step(12);
        bus.btnUp = 1'b0;
        step(12);
        chk("release_no_event", {29'd0, bus.codeOut}, 1);

        // glitches shorter than the debounce window
        rst = 1'b1; step(1); rst = 1'b0; step(2);
        for (int r = 0; r < 10; r++) begin
            bus.btnUp = 1'b1; step(3);
            bus.btnUp = 1'b0; step(1);
        end
        step(8);
        chk("glitch_code", {29'd0, bus.codeOut}, 0);

        // eight ups wrap, then one down
        for (int p = 0; p < 8; p++) begin
            press_up();
            chk("up_seq", {29'd0, bus.codeOut}, (p + 1) % 8);
        end
        bus.btnDown = 1'b1; step(8);
        bus.btnDown = 1'b0; step(8);
        chk("down_wrap", {29'd0, bus.codeOut}, 7);

        // simultaneous up and down cancel
        bus.btnUp = 1'b1; bus.btnDown = 1'b1; step(15);
        chk("cancel_code", {29'd0, bus.codeOut}, 7);
        bus.btnUp = 1'b0; bus.btnDown = 1'b0; step(10);
        chk("cancel_after", {29'd0, bus.codeOut}, 7);

        // auto-run from reset
        bus.autoRun = 1'b1; rst = 1'b1; step(2); rst = 1'b0;
        step(10);
        chk("auto_first_before", {29'd0, bus.codeOut}, 0);
        step(1);
        chk("auto_first", {29'd0, bus.codeOut}, 1);
        chk("auto_first_pulse", {31'd0, bus.stepPulse}, 1);
        step(8 * 7);
        chk("auto_wrap", {29'd0, bus.codeOut}, 0);

        // down press mid-interval restarts the interval
        bus.btnDown = 1'b1;
        step(6);
        chk("auto_down_before", {29'd0, bus.codeOut}, 0);
        step(1);
        chk("auto_down", {29'd0, bus.codeOut}, 7);
        bus.btnDown = 1'b0;
        step(7);
        chk("auto_after_down_hold", {29'd0, bus.codeOut}, 7);
        step(1);
        chk("auto_after_down", {29'd0, bus.codeOut}, 0);

        // reset mid-count at code 5
        lim = 0;
        while (bus.codeOut !== 3'd5 && lim < 80) begin step(1); lim++; end
        chk("reach_five", {29'd0, bus.codeOut}, 5);
        step(3);
        rst = 1'b1; step(1); rst = 1'b0;
        chk("midrun_reset", {29'd0, bus.codeOut}, 0);
        step(10);
        chk("resync_before", {29'd0, bus.codeOut}, 0);
        step(1);
        chk("resync_first", {29'd0, bus.codeOut}, 1);

        // button held through reset release counts as a press
        bus.autoRun = 1'b0; bus.btnUp = 1'b1; rst = 1'b1; step(3); rst = 1'b0;
        step(6);
        chk("held_before", {29'd0, bus.codeOut}, 0);
        step(1);
        chk("held_press", {29'd0, bus.codeOut}, 1);
        step(20);
        chk("held_no_repeat", {29'd0, bus.codeOut}, 1);
        bus.btnUp = 1'b0; step(8);

        // random traffic against the model
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 5) == 0)  bus.btnUp = ~bus.btnUp;
            if ($urandom_range(0, 6) == 0)  bus.btnDown = ~bus.btnDown;
            if ($urandom_range(0, 60) == 0) bus.autoRun = ~bus.autoRun;
            rst = ($urandom_range(0, 150) == 0) ? 1'b1 : 1'b0;
            step(1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/code_stepper.md
CODE_STEPPER -- requirements
Module: code_stepper

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 500000, meaning consecutive stable cycles required to accept a button level change (10 ms at 50 MHz).
REQ-002 The block SHALL have parameter STEP_DIV, default 25000000, meaning clock cycles between automatic steps (0.5 s at 50 MHz).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge triggered.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port btnUp, input, 1 bit: raw asynchronous push-button, active-high, increments the code.
REQ-006 The block SHALL have port btnDown, input, 1 bit: raw asynchronous push-button, active-high, decrements the code.
REQ-007 The block SHALL have port autoRun, input, 1 bit: raw slide switch; when 1, the code increments every STEP_DIV cycles.
REQ-008 The block SHALL have port codeOut, output, 3 bits: registered code that drives the 3-to-8 LED decoder's codeIn.
REQ-009 The block SHALL have port stepPulse, output, 1 bit: registered, high for exactly one cycle in the first cycle that codeOut holds a new value.

Function
REQ-010 btnUp, btnDown and autoRun SHALL each pass through a 2-flop synchronizer before any other use.
REQ-011 Each synchronized button SHALL have a debounce filter with a stable level register and a counter of width clog2(DEBOUNCE_CYCLES).
- If the synced level equals the stable level, the counter SHALL clear to 0.
- Otherwise the counter SHALL increment.
- When the counter equals DEBOUNCE_CYCLES-1 and the synced level still differs, the stable level SHALL take the synced level and the counter SHALL clear.
REQ-012 A shorter glitch (any return to the stable level before the count completes) SHALL restart the count from 0 and produce no event.
REQ-013 A press event SHALL be a 0-to-1 transition of a stable level; releases SHALL produce no event.
REQ-014 codeOut SHALL update on the clock edge after a press event; total latency from raw rise (set up before edge 1) to new codeOut is DEBOUNCE_CYCLES+3 edges.
REQ-015 An up event SHALL set codeOut to codeOut+1 modulo 8 (7 -> 0).
REQ-016 A down event SHALL set codeOut to codeOut-1 modulo 8 (0 -> 7).
REQ-017 Simultaneous up and down events in the same cycle SHALL leave codeOut unchanged and SHALL NOT assert stepPulse.
REQ-018 A 2-state run FSM SHALL use IDLE (synced autoRun=0) and RUN (synced autoRun=1).
- Entering RUN SHALL clear the prescaler.
- In IDLE the prescaler SHALL hold at 0.
REQ-019 In RUN the prescaler SHALL count 0..STEP_DIV-1; at STEP_DIV-1 it SHALL wrap to 0 and generate an auto-up step.
REQ-020 Any manual event (up, down or cancelling pair) in RUN SHALL clear the prescaler; a manual event SHALL take precedence over an auto step in the same cycle, and the auto step is discarded.
REQ-021 stepPulse SHALL assert only when codeOut actually changed value on the preceding edge.
REQ-022 A held button SHALL generate exactly one event per press, with no auto-repeat.

Reset
REQ-023 While rst=1 at a clock edge, the following SHALL all clear to 0:
- codeOut=3'b000 and stepPulse=0;
- synchronizers, stable levels, debounce counters and prescaler;
- run FSM returns to IDLE.
REQ-024 Reset asserted mid-debounce or mid-prescale SHALL discard the partial count; no event SHALL be generated by the reset itself.
REQ-025 A button held high through reset release SHALL be treated as a new press and generate one event after the full latency of REQ-014.

Verification (DEBOUNCE_CYCLES=4, STEP_DIV=8 for bench)
REQ-026 Reset, then pulse btnUp high for 20 cycles -> codeOut 0->1 exactly 7 edges after the rise, stepPulse high for exactly 1 cycle, no further change on release.
REQ-027 btnUp glitches of 3 cycles high / 1 cycle low repeated for 40 cycles -> codeOut stays 0 and stepPulse never asserts.
REQ-028 Eight clean btnUp presses from 0 -> codeOut 1,2,...,7,0; then one btnDown press -> codeOut 7.
REQ-029 btnUp and btnDown raised in the same cycle and held -> codeOut unchanged and no stepPulse.
REQ-030 autoRun=1 from reset -> codeOut increments every 8 cycles and wraps 7->0; a btnDown press mid-interval -> decrement, then the next auto step occurs 8 cycles after that event.
REQ-031 Assert rst for 1 cycle during an autoRun count with codeOut=5 -> codeOut=0 next cycle, and the first auto step occurs a full interval after the re-synchronized autoRun re-enters RUN.
